// File: rtl/rf_dump_pkg.sv
// rf_dump_pkg: shared constants, FSM state, FIFO beat layout for the register-file dump streamer
package rf_dump_pkg;
    localparam int REG_MAX = 32;
    localparam int REG_SIZE = 32;
    localparam int IDX_W = 5;
    localparam int FIFO_DEPTH = 2;
    typedef logic [IDX_W:0] cnt_t;
    localparam cnt_t LAST_IDX = cnt_t'(REG_MAX - 1);
    localparam cnt_t END_IDX = cnt_t'(REG_MAX);
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    typedef struct packed {
        logic [REG_SIZE-1:0] data;
        logic [IDX_W-1:0] index;
        logic last;
    } beat_t;
endpackage

// File: rtl/rf_dump_if.sv
// rf_dump_if: valid/ready dump stream; master = streamer, slave = sink
// out_valid/out_data/out_index/out_last flow master->slave, out_ready flows back
interface rf_dump_if;
    import rf_dump_pkg::*;
    logic out_valid;
    logic out_ready;
    logic [REG_SIZE-1:0] out_data;
    logic [IDX_W-1:0] out_index;
    logic out_last;
    modport master (output out_valid, out_data, out_index, out_last, input out_ready);
    modport slave (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/rf_dump_fifo.sv
// rf_dump_fifo: 2-entry synchronous beat FIFO
// ports: clk, rst_n (async low), push/din in, pop in, dout = head, full/empty/count status
module rf_dump_fifo
    import rf_dump_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  beat_t      din,
    output beat_t      dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);
    beat_t [1:0] mem_q, mem_d;
    logic wr_q, wr_d, rd_q, rd_d;
    logic [1:0] count_q, count_d;
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_q] = din;
        wr_d = wr_q ^ push;
        rd_d = rd_q ^ pop;
        count_d = count_q + 2'(push) - 2'(pop);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            count_q <= count_d;
        end
    end
    assign dout = mem_q[rd_q];
    assign full = count_q == 2'd2;
    assign empty = count_q == 2'd0;
    assign count = count_q;
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));
endmodule

// File: rtl/rf_dump_streamer.sv
// rf_dump_streamer: on start, reads registers 0..REG_MAX-1 over a debug port and streams them out
// ports: clk, rst_n (async low), start in, busy/done status, rf_rd_en/rf_rd_addr/rf_rd_data debug read port,
//        out = rf_dump_if master stream (data, index, last per beat)
module rf_dump_streamer
    import rf_dump_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                rf_rd_en,
    output logic [IDX_W-1:0]    rf_rd_addr,
    input  logic [REG_SIZE-1:0] rf_rd_data,
    rf_dump_if.master           out
);
    state_t state_q, state_d;
    cnt_t issue_q, issue_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic pop, full, empty;
    logic [1:0] count;
    beat_t head, beat_in;
    assign pop = !empty && out.out_ready;
    // a read may issue into a full FIFO only when the head leaves on the same edge
    assign rf_rd_en = state_q == RUN && issue_q < END_IDX && (!full || pop);
    rf_dump_fifo u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(rf_rd_en),
        .pop(pop),
        .din(beat_in),
        .dout(head),
        .full(full),
        .empty(empty),
        .count(count)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            issue_q <= '0;
            addr_q <= '0;
        end else begin
            state_q <= state_d;
            issue_q <= issue_d;
            addr_q <= addr_d;
        end
    end
    // FLUSH is entered on the edge that pushes the last read, so the last pop always happens in FLUSH
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = start ? RUN : IDLE;
            RUN: state_d = (rf_rd_en && issue_q == LAST_IDX) ? FLUSH : RUN;
            FLUSH: state_d = (pop && head.last) ? DONE : FLUSH;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        issue_d = (state_q == IDLE && start) ? '0 : issue_q + cnt_t'(rf_rd_en);
        addr_d = rf_rd_en ? issue_q[IDX_W-1:0] : addr_q;
        beat_in = '{data: rf_rd_data, index: issue_q[IDX_W-1:0], last: issue_q == LAST_IDX};
        busy = state_q == RUN || state_q == FLUSH;
        done = state_q == DONE;
        rf_rd_addr = addr_d;
    end
    assign out.out_valid = !empty;
    assign out.out_data = head.data;
    assign out.out_index = head.index;
    assign out.out_last = head.last;
    a_fifo_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= 2'(FIFO_DEPTH));
endmodule

// File: tb/tb_rf_dump_streamer.sv
// tb_rf_dump_streamer: directed table plus scripted dump sequences against a bench-side model
module tb_rf_dump_streamer;
    import rf_dump_pkg::*;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done, rf_rd_en;
    logic [IDX_W-1:0] rf_rd_addr;
    logic [REG_SIZE-1:0] rf_rd_data;
    logic [REG_SIZE-1:0] rf [REG_MAX];
    int nvec = 0, nerr = 0;
    typedef struct {
        bit start, ready, valid;
        int index;
        bit rd_en;
        int addr;
        bit busy, done;
    } vec_t;
    rf_dump_if bus ();
    rf_dump_streamer dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .rf_rd_en(rf_rd_en),
        .rf_rd_addr(rf_rd_addr),
        .rf_rd_data(rf_rd_data),
        .out(bus)
    );
    always #5 clk = ~clk;
    assign rf_rd_data = rf[rf_rd_addr];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step_in(input bit rdy);
        @(posedge clk);
        #1;
        start = 1'b0;
        bus.out_ready = rdy;
        #1;
    endtask
    task automatic chk_reset(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".rd_en"}, rf_rd_en, 0);
        check({tag, ".rd_addr"}, rf_rd_addr, 0);
        check({tag, ".valid"}, bus.out_valid, 0);
        check({tag, ".data"}, bus.out_data, 0);
        check({tag, ".index"}, bus.out_index, 0);
        check({tag, ".last"}, bus.out_last, 0);
    endtask
    task automatic run_dump(input bit toggle, input bit restarts, input int abort_at);
        int exp_idx = 0, cnt = 0, issue = 0, last_cyc = 1000, dones = 0;
        bit stall = 0, restarted = 0, pop;
        logic [REG_SIZE-1:0] hd = '0;
        logic [IDX_W-1:0] hi = '0;
        logic hl = 1'b0;
        for (int cyc = 0; cyc < 300 && cyc <= last_cyc + 3; cyc++) begin
            step_in(toggle ? (cyc % 2 == 0) : 1'b1);
            if (stall) begin
                check("hold.valid", bus.out_valid, 1);
                check("hold.data", bus.out_data, hd);
                check("hold.index", bus.out_index, hi);
                check("hold.last", bus.out_last, hl);
            end
            check("valid", bus.out_valid, cnt > 0);
            check("busy", busy, cyc >= 1 && !(exp_idx == REG_MAX && cyc > last_cyc));
            check("done", done, exp_idx == REG_MAX && cyc == last_cyc + 1);
            dones += int'(done);
            pop = bus.out_valid && bus.out_ready;
            if (cnt == 2 && !pop) check("full.rd_en", rf_rd_en, 0);
            if (rf_rd_en) begin
                check("rd_addr", rf_rd_addr, issue);
                issue++;
            end
            if (pop) begin
                check("beat.index", bus.out_index, exp_idx);
                check("beat.data", bus.out_data, rf[exp_idx]);
                check("beat.last", bus.out_last, exp_idx == REG_MAX - 1);
                if (!toggle) check("beat.time", cyc, exp_idx + 2);
                if (exp_idx == REG_MAX - 1) last_cyc = cyc;
                exp_idx++;
            end
            cnt = cnt + int'(rf_rd_en) - int'(pop);
            stall = bus.out_valid && !bus.out_ready;
            hd = bus.out_data;
            hi = bus.out_index;
            hl = bus.out_last;
            if (cyc == 0 || (restarts && done)) start = 1'b1;
            if (restarts && exp_idx == 5 && !restarted) begin
                start = 1'b1;
                restarted = 1;
            end
            if (abort_at >= 0 && exp_idx == abort_at) begin
                #1 rst_n = 1'b0;
                #1 chk_reset("abort");
                check("abort.dones", dones, 0);
                #3 rst_n = 1'b1;
                return;
            end
        end
        check("beats", exp_idx, REG_MAX);
        check("done_count", dones, 1);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
    initial begin
        vec_t vt [15];
        int nx, dcount;
        vt[0] = '{1, 0, 0, 0, 0, 0, 0, 0};
        vt[1] = '{0, 0, 0, 0, 1, 0, 1, 0};
        vt[2] = '{0, 0, 1, 0, 1, 1, 1, 0};
        for (int i = 3; i <= 10; i++) vt[i] = '{0, 0, 1, 0, 0, 1, 1, 0};
        vt[11] = '{0, 1, 1, 0, 1, 2, 1, 0};
        vt[12] = '{0, 0, 1, 1, 0, 2, 1, 0};
        vt[13] = '{0, 1, 1, 1, 1, 3, 1, 0};
        vt[14] = '{0, 1, 1, 2, 1, 4, 1, 0};
        for (int i = 0; i < REG_MAX; i++) rf[i] = 32'h1000_0000 + i;
        bus.out_ready = 1'b0;
        #12 chk_reset("reset");
        #1 rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step_in(vt[i].ready);
            check($sformatf("vec%0d.valid", i), bus.out_valid, vt[i].valid);
            check($sformatf("vec%0d.rd_en", i), rf_rd_en, vt[i].rd_en);
            check($sformatf("vec%0d.rd_addr", i), rf_rd_addr, vt[i].addr);
            check($sformatf("vec%0d.busy", i), busy, vt[i].busy);
            check($sformatf("vec%0d.done", i), done, vt[i].done);
            if (vt[i].valid) begin
                check($sformatf("vec%0d.index", i), bus.out_index, vt[i].index);
                check($sformatf("vec%0d.data", i), bus.out_data, 32'h1000_0000 + vt[i].index);
            end
            if (vt[i].start) start = 1'b1;
        end
        nx = 3;
        dcount = 0;
        for (int c = 0; c < 100 && dcount == 0; c++) begin
            step_in(1'b1);
            if (done) dcount++;
            if (bus.out_valid) begin
                check("drain.index", bus.out_index, nx);
                check("drain.data", bus.out_data, 32'h1000_0000 + nx);
                check("drain.last", bus.out_last, nx == REG_MAX - 1);
                nx++;
            end
        end
        check("drain.beats", nx, REG_MAX);
        check("drain.done", dcount, 1);
        run_dump(0, 0, -1);
        run_dump(1, 0, -1);
        run_dump(0, 1, -1);
        run_dump(0, 0, 12);
        for (int c = 0; c < 4; c++) begin
            step_in(1'b1);
            check("post_abort.done", done, 0);
            check("post_abort.busy", busy, 0);
            check("post_abort.valid", bus.out_valid, 0);
        end
        run_dump(0, 0, -1);
        rf[0] = 32'hDEAD_BEEF;
        rf[REG_MAX-1] = 32'hFFFF_FFFF;
        run_dump(0, 0, -1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rf_dump_streamer.md
Name: rf_dump_streamer

Overview:
- Hardware counterpart of the register-file dump step: on a start pulse, reads all architectural registers of the CPU register file in index order and streams them out over a valid/ready interface.
- Sits beside Register_File on a dedicated debug read port and feeds a downstream sink such as a UART or trace buffer.
- Makes end-of-run register state observable without hierarchical access.

Parameters:
- REG_MAX, 32, number of registers dumped (indices 0..REG_MAX-1).
- REG_SIZE, 32, register width in bits.
- IDX_W, 5, index width; must equal clog2(REG_MAX).
- FIFO_DEPTH, 2, output buffer entries; fixed at 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a dump; sampled only in IDLE.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse after the last beat is accepted.
- rf_rd_en  output  1  debug read strobe to the register file.
- rf_rd_addr  output  IDX_W  debug read index.
- rf_rd_data  input  REG_SIZE  register file read data, combinational from rf_rd_addr.
- out_valid  output  1  stream beat valid.
- out_ready  input  1  sink ready.
- out_data  output  REG_SIZE  register value.
- out_index  output  IDX_W  register index of this beat.
- out_last  output  1  high on the beat with out_index == REG_MAX-1.

Behaviour:
- Reset (async, rst_n low): state IDLE; busy=0, done=0, rf_rd_en=0, rf_rd_addr=0, out_valid=0, out_data=0, out_index=0, out_last=0; FIFO emptied; counters cleared. Reset mid-dump aborts it with no done pulse.
- States and transitions:
  - IDLE -> RUN on the clk edge where start=1. busy rises after that edge.
  - RUN -> FLUSH when the issue counter reaches REG_MAX.
  - FLUSH -> DONE when the beat with out_last=1 is accepted (out_valid&&out_ready).
  - DONE -> IDLE unconditionally after 1 cycle.
  - done=1 only in DONE; busy=1 in RUN and FLUSH.
- Issue: rf_rd_en = RUN && issue_idx < REG_MAX && (fifo_count < 2 || pop).
  - pop = out_valid && out_ready.
  - rf_rd_addr = issue_idx while rf_rd_en; otherwise holds its last value.
  - On each edge with rf_rd_en=1: push {rf_rd_data, issue_idx} into the FIFO and increment issue_idx.
- FIFO: 2 entries. Simultaneous push and pop at count 2 is legal and count stays 2. Push at count 2 without pop never occurs (assertion). Pop on empty is impossible because out_valid = !empty.
- Output: out_data, out_index and out_last come from the FIFO head. They are held stable while out_valid && !out_ready (AXI-style). out_valid never deasserts without a pop.
- Latency with out_ready held high (E0 = edge sampling start):
  - beat 0 valid after E1 and accepted at E2;
  - beat k accepted at E(k+2), so beat 31 is accepted at E33;
  - done is high for the cycle after E33; busy falls at E33.
  - Sustained throughput is 1 word per cycle.
- Backpressure: at most 2 words are buffered. Reads stall (rf_rd_en=0) while the FIFO is full and no pop occurs. No word is lost or duplicated.
- start while busy or in DONE is ignored; no queuing.
- Index arithmetic: issue_idx is IDX_W+1 bits so that REG_MAX is representable; out_index is truncated to IDX_W bits.
- Register 0 is dumped as read, with no forcing to zero.

Decomposition:
- Shared package rf_dump_pkg:
  - state enum {IDLE, RUN, FLUSH, DONE};
  - constants REG_MAX, REG_SIZE, IDX_W;
  - packed beat struct {data, index, last}.
- One sub-module: rf_dump_fifo, a 2-entry synchronous FIFO with async active-low reset, push/pop/full/empty/count ports.
- The top level holds the FSM and the issue counter.

Test Plan:
- Register file preloaded with R[i]=32'h1000_0000+i, start pulse, out_ready=1 -> 32 beats on consecutive cycles with data 0x10000000..0x1000001F and index 0..31; out_last only on index 31; done pulses 1 cycle after E33.
- Same preload, out_ready toggling 1,0,1,0 -> every beat delivered exactly once in order; data stable during stalls; rf_rd_en low whenever the FIFO is full without a pop.
- out_ready=0 for 10 cycles after start -> exactly 2 reads issued (addr 0,1), then rf_rd_en=0 and out_valid=1 holding index 0 until ready rises.
- start reasserted at beat 5 and again during DONE -> ignored; exactly 32 beats and one done pulse.
- rst_n pulsed low at beat 12 -> outputs return to their reset values immediately (async); no done pulse. A new start then produces a full dump from index 0.
- Preload R[31]=32'hFFFF_FFFF, R[0]=32'hDEAD_BEEF -> beat 0 data 0xDEADBEEF; last beat data 0xFFFFFFFF with out_last=1.
